// File: rtl/ws2812_rx.sv
// ws2812_rx: decodes a WS2812 serial line into GRB pixel strobes with frame-gap, error and overflow flags.
// Run lengths are measured on the synchronised line; every output is registered.
module ws2812_rx #(
    parameter int LED_COUNT            = 512,
    parameter int REVERSE              = 0,
    parameter int CYCLES_HIGH_MIN      = 5,
    parameter int CYCLES_BIT_THRESHOLD = 32,
    parameter int CYCLES_HIGH_MAX      = 100,
    parameter int CYCLES_RESET         = 2500
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       data_i,
    output logic       pixel_valid_o,
    output logic [8:0] address_o,
    output logic [7:0] r_o,
    output logic [7:0] g_o,
    output logic [7:0] b_o,
    output logic       frame_end_o,
    output logic       error_o,
    output logic       overflow_o
);
    localparam logic [11:0] HMIN = 12'(CYCLES_HIGH_MIN);
    localparam logic [11:0] THR  = 12'(CYCLES_BIT_THRESHOLD);
    localparam logic [11:0] HMAX = 12'(CYCLES_HIGH_MAX);
    localparam logic [11:0] RST  = 12'(CYCLES_RESET);
    localparam logic [9:0]  LEDS = 10'(LED_COUNT);

    typedef enum logic [1:0] {HUNT, LOW, HIGH} state_t;

    state_t      state_q, state_d;
    logic        s1_q, s_q, s_prev_q;
    logic [11:0] run_q, run_d;
    logic [4:0]  bit_cnt_q, bit_cnt_d;
    logic [23:0] sr_q, sr_d;
    logic        seen_q, seen_d;
    logic        pend_q, pend_d;
    logic [9:0]  index_q, index_d;
    logic        pv_q, pv_d, fe_q, fe_d, err_q, err_d, ov_q, ov_d;
    logic [8:0]  addr_q, addr_d;
    logic [7:0]  r_q, r_d, g_q, g_d, b_q, b_d;
    logic        rise, fall, gap;

    assign rise = s_q & ~s_prev_q;
    assign fall = ~s_q & s_prev_q;
    // run_q holds the length of a low run while the line is low and on the cycle it rises
    assign gap  = ~s_prev_q && run_q == RST;
    assign run_d = (s_q != s_prev_q) ? 12'd1 : (run_q == 12'hFFF ? run_q : run_q + 12'd1);

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        sr_d      = sr_q;
        seen_d    = seen_q;
        pend_d    = 1'b0;
        index_d   = index_q;
        pv_d      = 1'b0;
        fe_d      = 1'b0;
        err_d     = 1'b0;
        ov_d      = ov_q;
        addr_d    = addr_q;
        r_d       = r_q;
        g_d       = g_q;
        b_d       = b_q;
        if (pend_q) begin
            if (index_q < LEDS) begin
                pv_d    = 1'b1;
                g_d     = sr_q[23:16];
                r_d     = sr_q[15:8];
                b_d     = sr_q[7:0];
                addr_d  = REVERSE != 0 ? 9'(LEDS - 10'd1 - index_q) : index_q[8:0];
                index_d = index_q + 10'd1;
            end else begin
                ov_d = 1'b1;
            end
        end
        case (state_q)
            HUNT: begin
                if (gap) begin
                    // a rise can land on the very cycle the gap completes
                    state_d   = rise ? HIGH : LOW;
                    bit_cnt_d = '0;
                    index_d   = '0;
                    seen_d    = 1'b0;
                    ov_d      = 1'b0;
                end
            end
            LOW: begin
                if (gap) begin
                    fe_d      = seen_q;
                    err_d     = seen_q && bit_cnt_q != 5'd0;
                    bit_cnt_d = '0;
                    index_d   = '0;
                    seen_d    = 1'b0;
                    ov_d      = 1'b0;
                end
                if (rise) state_d = HIGH;
            end
            HIGH: begin
                if (run_q == HMAX) begin
                    err_d   = 1'b1;
                    state_d = HUNT;
                end else if (fall) begin
                    if (run_q < HMIN) begin
                        err_d   = 1'b1;
                        state_d = HUNT;
                    end else begin
                        sr_d      = {sr_q[22:0], run_q >= THR};
                        seen_d    = 1'b1;
                        pend_d    = bit_cnt_q == 5'd23;
                        bit_cnt_d = bit_cnt_q == 5'd23 ? 5'd0 : bit_cnt_q + 5'd1;
                        state_d   = LOW;
                    end
                end
            end
            default: state_d = HUNT;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= HUNT;
            s1_q      <= 1'b0;
            s_q       <= 1'b0;
            s_prev_q  <= 1'b0;
            run_q     <= '0;
            bit_cnt_q <= '0;
            sr_q      <= '0;
            seen_q    <= 1'b0;
            pend_q    <= 1'b0;
            index_q   <= '0;
            pv_q      <= 1'b0;
            fe_q      <= 1'b0;
            err_q     <= 1'b0;
            ov_q      <= 1'b0;
            addr_q    <= '0;
            r_q       <= '0;
            g_q       <= '0;
            b_q       <= '0;
        end else begin
            state_q   <= state_d;
            s1_q      <= data_i;
            s_q       <= s1_q;
            s_prev_q  <= s_q;
            run_q     <= run_d;
            bit_cnt_q <= bit_cnt_d;
            sr_q      <= sr_d;
            seen_q    <= seen_d;
            pend_q    <= pend_d;
            index_q   <= index_d;
            pv_q      <= pv_d;
            fe_q      <= fe_d;
            err_q     <= err_d;
            ov_q      <= ov_d;
            addr_q    <= addr_d;
            r_q       <= r_d;
            g_q       <= g_d;
            b_q       <= b_d;
        end
    end

    assign pixel_valid_o = pv_q;
    assign address_o     = addr_q;
    assign r_o           = r_q;
    assign g_o           = g_q;
    assign b_o           = b_q;
    assign frame_end_o   = fe_q;
    assign error_o       = err_q;
    assign overflow_o    = ov_q;
endmodule

// File: tb/tb_ws2812_rx.sv
// tb_ws2812_rx: drives one line into three differently configured receivers and checks them
// every cycle against a segment-level protocol model plus a few literal expectations.
module tb_ws2812_rx;
    localparam int C_RESET = 2500, C_HMIN = 5, C_THR = 32, C_HMAX = 100;

    logic clk = 1'b0, rst_n_i = 1'b0, data_i = 1'b0;
    always #5 clk = ~clk;

    logic [2:0] pv, fe, er, ov;
    logic [8:0] ad [3];
    logic [7:0] rr [3], gg [3], bb [3];

    ws2812_rx #(.LED_COUNT(512), .REVERSE(0)) u0 (.clk_i(clk), .rst_n_i(rst_n_i), .data_i(data_i),
        .pixel_valid_o(pv[0]), .address_o(ad[0]), .r_o(rr[0]), .g_o(gg[0]), .b_o(bb[0]),
        .frame_end_o(fe[0]), .error_o(er[0]), .overflow_o(ov[0]));
    ws2812_rx #(.LED_COUNT(8), .REVERSE(1)) u1 (.clk_i(clk), .rst_n_i(rst_n_i), .data_i(data_i),
        .pixel_valid_o(pv[1]), .address_o(ad[1]), .r_o(rr[1]), .g_o(gg[1]), .b_o(bb[1]),
        .frame_end_o(fe[1]), .error_o(er[1]), .overflow_o(ov[1]));
    ws2812_rx #(.LED_COUNT(2), .REVERSE(0)) u2 (.clk_i(clk), .rst_n_i(rst_n_i), .data_i(data_i),
        .pixel_valid_o(pv[2]), .address_o(ad[2]), .r_o(rr[2]), .g_o(gg[2]), .b_o(bb[2]),
        .frame_end_o(fe[2]), .error_o(er[2]), .overflow_o(ov[2]));

    int led [3] = '{512, 8, 2};
    int rev [3] = '{0, 1, 0};

    int passed = 0, total = 0, cyc = 0;
    int n_pv [3], n_fe [3], n_err [3], n_both [3], last_col [3];
    bit [2:0] eov;

    typedef struct {int k; int addr; int col;} ent_t;
    ent_t plog [$];

    // expected events keyed by the cycle on which the registered output shows them
    int pix_col [int];
    int pix_idx [int];
    bit fe_at [int], err_at [int], ovclr_at [int];

    int hunt, mbits, msr, midx, mseen;
    bit q_lvl [$];
    int q_len [$];
    int last_lvl = 2, last_n = 0, last_len = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: actual %0h required %0h (cycle %0d)", nm, act, exp, cyc);
    endtask

    task automatic mreset();
        hunt = 1; mbits = 0; msr = 0; midx = 0; mseen = 0; last_lvl = 2;
    endtask

    // one line segment of constant level starting at drive cycle n
    task automatic model_seg(input bit lvl, input int len, input int n);
        int t;
        if (!lvl) begin
            if (len >= C_RESET) begin
                t = n + 3 + C_RESET;
                if (!hunt && mseen) begin
                    fe_at[t] = 1;
                    if (mbits != 0) err_at[t] = 1;
                end
                hunt = 0; ovclr_at[t] = 1; mbits = 0; midx = 0; mseen = 0;
            end
        end else if (!hunt) begin
            if (len >= C_HMAX) begin
                err_at[n + 3 + C_HMAX] = 1; hunt = 1;
            end else if (len < C_HMIN) begin
                err_at[n + len + 3] = 1; hunt = 1;
            end else begin
                msr = ((msr << 1) | int'(len >= C_THR)) & 32'hFFFFFF;
                mseen = 1;
                mbits++;
                if (mbits == 24) begin
                    mbits = 0;
                    pix_col[n + len + 4] = msr;
                    pix_idx[n + len + 4] = midx;
                    midx++;
                end
            end
        end
    endtask

    task automatic push(input bit lvl, input int len);
        if (q_lvl.size() > 0 && q_lvl[q_lvl.size()-1] == lvl) q_len[q_len.size()-1] += len;
        else begin q_lvl.push_back(lvl); q_len.push_back(len); end
    endtask

    task automatic pix(input logic [23:0] v, input int h1 = 42, input int h0 = 21);
        for (int i = 23; i >= 0; i--) begin
            push(1'b1, v[i] ? h1 : h0);
            push(1'b0, v[i] ? 63 - h1 : 63 - h0);
        end
    endtask

    task automatic play();
        bit l;
        int n;
        while (q_lvl.size() > 0) begin
            l = q_lvl.pop_front();
            n = q_len.pop_front();
            data_i = l;
            // a low continuing across two plays is one run on the wire
            if (!l && last_lvl == 0) begin
                last_len += n;
                model_seg(1'b0, last_len, last_n);
            end else begin
                last_lvl = int'(l); last_n = cyc; last_len = n;
                model_seg(l, n, cyc);
            end
            repeat (n) @(posedge clk);
            #1;
        end
    endtask

    always @(negedge clk) begin
        bit ep;
        int ix;
        for (int k = 0; k < 3; k++) begin
            ix = pix_idx.exists(cyc) ? pix_idx[cyc] : -1;
            ep = pix_col.exists(cyc) && ix < led[k];
            if (!rst_n_i) eov[k] = 1'b0;
            else begin
                if (ix >= led[k]) eov[k] = 1'b1;
                if (ovclr_at.exists(cyc)) eov[k] = 1'b0;
            end
            chk($sformatf("pixel_valid%0d", k), int'(pv[k]), int'(ep));
            chk($sformatf("frame_end%0d", k), int'(fe[k]), int'(fe_at.exists(cyc)));
            chk($sformatf("error%0d", k), int'(er[k]), int'(err_at.exists(cyc)));
            chk($sformatf("overflow%0d", k), int'(ov[k]), int'(eov[k]));
            if (ep) begin
                chk($sformatf("address%0d", k), int'(ad[k]), rev[k] != 0 ? led[k] - 1 - ix : ix);
                chk($sformatf("grb%0d", k), int'({gg[k], rr[k], bb[k]}), pix_col[cyc]);
            end
            if (pv[k]) begin
                n_pv[k]++;
                last_col[k] = int'({gg[k], rr[k], bb[k]});
                plog.push_back('{k, int'(ad[k]), int'({gg[k], rr[k], bb[k]})});
            end
            if (fe[k]) n_fe[k]++;
            if (er[k]) n_err[k]++;
            if (fe[k] && er[k]) n_both[k]++;
        end
    end

    initial begin
        int b0, b1, b2, np, r, hl;
        mreset();
        repeat (3) @(posedge clk);
        #1 rst_n_i = 1'b1;

        // two pixels, all three configurations
        push(1'b0, 2600); pix(24'h00FF00); pix(24'h123456); push(1'b0, 2600); play();
        chk("t1_strobes", plog.size(), 6);
        if (plog.size() == 6) begin
            chk("t1_addr0", plog[0].addr, 0);   chk("t1_col0", plog[0].col, 24'h00FF00);
            chk("t1_addr1", plog[3].addr, 1);   chk("t1_col1", plog[3].col, 24'h123456);
            chk("t1_rev_a0", plog[1].addr, 7);  chk("t1_rev_a1", plog[4].addr, 6);
            chk("t1_rev_col", plog[4].col, 24'h123456);
        end
        chk("t1_frame_end", n_fe[0], 1);
        chk("t1_error", n_err[0], 0);

        // LED_COUNT=2 overflows on the third pixel
        b2 = n_pv[2]; b0 = n_fe[2];
        pix(24'hA1B2C3); pix(24'h0F0F0F); pix(24'hF00F0F); play();
        chk("t2_strobes", n_pv[2] - b2, 2);
        chk("t2_ov_set", int'(ov[2]), 1);
        chk("t2_ov_wide", int'(ov[0]), 0);
        push(1'b0, 2600); play();
        chk("t2_frame_end", n_fe[2] - b0, 1);
        chk("t2_ov_clear", int'(ov[2]), 0);

        // partial pixel then gap, then a clean frame
        b0 = n_both[0]; b1 = n_pv[0];
        for (int i = 0; i < 10; i++) begin push(1'b1, 42); push(1'b0, 21); end
        push(1'b0, 2600); play();
        chk("t3_err_fe", n_both[0] - b0, 1);
        chk("t3_no_pixel", n_pv[0] - b1, 0);
        pix(24'h336699); push(1'b0, 2600); play();
        chk("t3_next_pixel", n_pv[0] - b1, 1);
        chk("t3_next_col", last_col[0], 24'h336699);

        // short glitch mid-pixel, recovery only after a gap
        b0 = n_err[0]; b1 = n_pv[0];
        for (int i = 0; i < 5; i++) begin push(1'b1, 42); push(1'b0, 21); end
        push(1'b1, 3); push(1'b0, 40);
        for (int i = 0; i < 19; i++) begin push(1'b1, 21); push(1'b0, 42); end
        push(1'b0, 2600); pix(24'h010203); push(1'b0, 2600); play();
        chk("t4_error", n_err[0] - b0, 1);
        chk("t4_pixel", n_pv[0] - b1, 1);

        // overlong high
        b0 = n_err[0];
        push(1'b1, 120); push(1'b0, 2600); pix(24'hC0FFEE); push(1'b0, 2600); play();
        chk("t5_error", n_err[0] - b0, 1);
        chk("t5_col", last_col[0], 24'hC0FFEE);

        // bit threshold: high 31 is 0, high 32 is 1
        pix(24'hAAAAAA, 32, 31); push(1'b0, 2600); play();
        chk("t6_thr_a", last_col[0], 24'hAAAAAA);
        pix(24'h5A5A5A, 32, 31); push(1'b0, 2600); play();
        chk("t6_thr_b", last_col[0], 24'h5A5A5A);

        // randomized frames, occasional glitches and overlong highs
        for (int f = 0; f < 4; f++) begin
            np = $urandom_range(1, 3);
            for (int p = 0; p < np * 24; p++) begin
                r = $urandom_range(0, 99);
                hl = r == 0 ? $urandom_range(1, 4) : r == 1 ? $urandom_range(95, 130) : $urandom_range(5, 99);
                push(1'b1, hl);
                push(1'b0, $urandom_range(1, 200));
            end
            push(1'b0, $urandom_range(2500, 2600));
            play();
        end

        // reset mid-pixel while outputs hold non-zero values
        pix(24'h111111); pix(24'h222222); pix(24'h333333);
        for (int i = 0; i < 5; i++) begin push(1'b1, 42); push(1'b0, 21); end
        play();
        chk("t8_ov_before", int'(ov[2]), 1);
        #2 rst_n_i = 1'b0;
        #1;
        chk("t8_rst_ov", int'(ov), 0);
        chk("t8_rst_pv", int'(pv | fe | er), 0);
        chk("t8_rst_ad0", int'(ad[0]), 0);
        chk("t8_rst_col0", int'({gg[0], rr[0], bb[0]}), 0);
        chk("t8_rst_ad2", int'(ad[2]), 0);
        repeat (3) @(posedge clk);
        #1 rst_n_i = 1'b1;
        mreset();
        b1 = n_pv[0]; b0 = n_fe[0];
        push(1'b0, 10); pix(24'h445566); pix(24'h778899); push(1'b0, 2600); play();
        chk("t8_no_strobe", n_pv[0] - b1, 0);
        chk("t8_no_fe", n_fe[0] - b0, 0);
        pix(24'hABCDEF); push(1'b0, 2600); play();
        chk("t8_resync", n_pv[0] - b1, 1);
        chk("t8_resync_col", last_col[0], 24'hABCDEF);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
